instr_register_pipe: RTL

Parametrised successor to the lab instruction register: a DEPTH-entry register file of instructions (opcode, two operands) whose result is computed in a two-stage write pipeline and stored alongside the instruction. It adds per-entry valid and error bits, a registered read port with write-to-read forwarding, a bulk clear, and an occupancy counter. It sits between the instruction-loading testbench/driver and any consumer that reads back instruction words by address.

---
 rtl/instr_register_pkg.sv | 56 +++++
 rtl/instr_alu.sv | 26 ++
 rtl/instr_register_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register.
// Holds opcode_t, width defaults and the result/err function.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int DEF_DEPTH    = 32;
  localparam int DEF_OP_WIDTH = 32;
  // Widest operand the shared function handles.
  localparam int MAX_OP_WIDTH = 32;
  localparam int CALC_W       = 2 * MAX_OP_WIDTH;

  typedef struct packed {
    logic signed [CALC_W-1:0] result;
    logic                     err;
  } alu_out_t;

  // Operands arrive already sign-extended to CALC_W, so
  // the product and quotient can never overflow here.
  function automatic alu_out_t alu_calc(
    input opcode_t                  opc,
    input logic signed [CALC_W-1:0] a,
    input logic signed [CALC_W-1:0] b
  );
    alu_out_t o;
    o.result = '0;
    o.err    = 1'b0;
    unique case (opc)
      ZERO:  o.result = '0;
      PASSA: o.result = a;
      PASSB: o.result = b;
      ADD:   o.result = a + b;
      SUB:   o.result = a - b;
      MULT:  o.result = a * b;
      DIV: begin
        if (b == '0) o.err = 1'b1;
        else         o.result = a / b;
      end
      MOD: begin
        if (b == '0) o.err = 1'b1;
        else         o.result = a % b;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational result unit for one instruction.
// In: opc, a, b (signed OP_WIDTH). Out: result (2*OP_WIDTH), err.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = DEF_OP_WIDTH
) (
  input  opcode_t                     opc,
  input  logic signed [OP_WIDTH-1:0]  a,
  input  logic signed [OP_WIDTH-1:0]  b,
  output logic signed [2*OP_WIDTH-1:0] result,
  output logic                        err
);

  logic signed [CALC_W-1:0] a_x;
  logic signed [CALC_W-1:0] b_x;
  alu_out_t                 o;

  assign a_x = {{(CALC_W-OP_WIDTH){a[OP_WIDTH-1]}}, a};
  assign b_x = {{(CALC_W-OP_WIDTH){b[OP_WIDTH-1]}}, b};
  assign o   = alu_calc(opc, a_x, b_x);

  assign result = o.result[2*OP_WIDTH-1:0];
  assign err    = o.err;

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-entry instruction register, 2-stage write pipe, fwd read.
// In: load/write_pointer/opcode/operands, clear, read_pointer. Out: rd_*, valid_count.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int OP_WIDTH = DEF_OP_WIDTH,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_en,
  input  logic [AW-1:0]                write_pointer,
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  input  logic                         clear,
  input  logic [AW-1:0]                read_pointer,
  output opcode_t                      rd_opc,
  output logic signed [OP_WIDTH-1:0]   rd_op_a,
  output logic signed [OP_WIDTH-1:0]   rd_op_b,
  output logic signed [2*OP_WIDTH-1:0] rd_result,
  output logic                         rd_err,
  output logic                         rd_valid,
  output logic [AW:0]                  valid_count
);

  typedef struct packed {
    opcode_t                 opc;
    logic [OP_WIDTH-1:0]     a;
    logic [OP_WIDTH-1:0]     b;
    logic [2*OP_WIDTH-1:0]   res;
  } entry_t;

  logic                 e1_vld_q, e1_vld_d;
  logic [AW-1:0]        e1_addr_q, e1_addr_d;
  opcode_t              e1_opc_q, e1_opc_d;
  logic [OP_WIDTH-1:0]  e1_a_q, e1_a_d;
  logic [OP_WIDTH-1:0]  e1_b_q, e1_b_d;

  logic                 e2_vld_q, e2_vld_d;
  logic [AW-1:0]        e2_addr_q, e2_addr_d;
  entry_t               e2_ent_q, e2_ent_d;
  logic                 e2_err_q, e2_err_d;

  entry_t               mem_q [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     err_q, err_d;
  logic [AW:0]          cnt_q, cnt_d;

  entry_t               rd_ent_q, rd_ent_d;
  logic                 rd_err_q, rd_err_d;
  logic                 rd_vld_q, rd_vld_d;

  logic signed [2*OP_WIDTH-1:0] alu_res;
  logic                         alu_err;
  logic                         commit;
  logic                         fwd_hit;

  instr_alu #(
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .opc    (e1_opc_q),
    .a      (e1_a_q),
    .b      (e1_b_q),
    .result (alu_res),
    .err    (alu_err)
  );

  // A commit coinciding with clear is dropped.
  assign commit  = e2_vld_q & ~clear;
  assign fwd_hit = commit & (e2_addr_q == read_pointer);

  always_comb begin
    e1_vld_d  = load_en;
    e1_addr_d = e1_addr_q;
    e1_opc_d  = e1_opc_q;
    e1_a_d    = e1_a_q;
    e1_b_d    = e1_b_q;
    if (load_en) begin
      e1_addr_d = write_pointer;
      e1_opc_d  = opcode;
      e1_a_d    = operand_a;
      e1_b_d    = operand_b;
    end

    e2_vld_d  = e1_vld_q;
    e2_addr_d = e2_addr_q;
    e2_ent_d  = e2_ent_q;
    e2_err_d  = e2_err_q;
    if (e1_vld_q) begin
      e2_addr_d    = e1_addr_q;
      e2_ent_d.opc = e1_opc_q;
      e2_ent_d.a   = e1_a_q;
      e2_ent_d.b   = e1_b_q;
      e2_ent_d.res = alu_res;
      e2_err_d     = alu_err;
    end

    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clear) begin
      valid_d = '0;
      err_d   = '0;
      cnt_d   = '0;
    end else if (commit) begin
      valid_d[e2_addr_q] = 1'b1;
      err_d[e2_addr_q]   = e2_err_q;
      if (!valid_q[e2_addr_q]) cnt_d = cnt_q + (AW+1)'(1);
    end

    // Invalid entries read back as all zero.
    rd_ent_d = '0;
    rd_err_d = 1'b0;
    rd_vld_d = 1'b0;
    if (!clear) begin
      if (fwd_hit) begin
        rd_ent_d = e2_ent_q;
        rd_err_d = e2_err_q;
        rd_vld_d = 1'b1;
      end else if (valid_q[read_pointer]) begin
        rd_ent_d = mem_q[read_pointer];
        rd_err_d = err_q[read_pointer];
        rd_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e1_vld_q  <= 1'b0;
      e1_addr_q <= '0;
      e1_opc_q  <= ZERO;
      e1_a_q    <= '0;
      e1_b_q    <= '0;
      e2_vld_q  <= 1'b0;
      e2_addr_q <= '0;
      e2_ent_q  <= '0;
      e2_err_q  <= 1'b0;
      valid_q   <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
      rd_ent_q  <= '0;
      rd_err_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      e1_vld_q  <= e1_vld_d;
      e1_addr_q <= e1_addr_d;
      e1_opc_q  <= e1_opc_d;
      e1_a_q    <= e1_a_d;
      e1_b_q    <= e1_b_d;
      e2_vld_q  <= e2_vld_d;
      e2_addr_q <= e2_addr_d;
      e2_ent_q  <= e2_ent_d;
      e2_err_q  <= e2_err_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rd_ent_q  <= rd_ent_d;
      rd_err_q  <= rd_err_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // Data array is not reset; valid_q masks it.
  always_ff @(posedge clk) begin
    if (commit) mem_q[e2_addr_q] <= e2_ent_q;
  end

  assign rd_opc      = rd_ent_q.opc;
  assign rd_op_a     = rd_ent_q.a;
  assign rd_op_b     = rd_ent_q.b;
  assign rd_result   = rd_ent_q.res;
  assign rd_err      = rd_err_q;
  assign rd_valid    = rd_vld_q;
  assign valid_count = cnt_q;

endmodule
